g_sensor_int_servicer: RTL
==========================

# g_sensor_int_servicer

Avalon-MM master that services the accelerometer interrupt PIO (the single-bit edge-capture input port on the g-sensor INT line) in hardware instead of by the Nios II ISR. It arms the port's interrupt mask, waits for `irq`, reads and clears the edge-capture register, reads the live pin level, and presents a timestamped event on a valid/ready stream. It sits between the PIO slave's `s1` port, driven directly with no interconnect, and the sensor-sampling logic.

## Interface
- `TS_WIDTH`, 32: width of free-running timestamp counter and `evt_timestamp`.
- `CNT_WIDTH`, 16: width of serviced-event counter `evt_count`.

- `clk`  in  1  single system clock; every register is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; 1 = arm and service, 0 = disarm.
- `avm_address`  out  2  PIO register select: 0 data, 2 irq mask, 3 edge capture.
- `avm_chipselect`  out  1  high on every access cycle.
- `avm_write_n`  out  1  active-low write strobe.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  PIO read data. Fixed read latency 1: data for the address driven in cycle N is valid in cycle N+1.
- `irq`  in  1  PIO interrupt output.
- `evt_valid`  out  1  event available.
- `evt_ready`  in  1  consumer accepts the event when `evt_valid && evt_ready`.
- `evt_level`  out  1  pin level read after the clear.
- `evt_timestamp`  out  TS_WIDTH  timestamp counter value in the cycle `irq` was sampled.
- `evt_count`  out  CNT_WIDTH  serviced-event count including this event.
- `overflow`  out  1  sticky; an event was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.
- `busy`  out  1  high in every state except IDLE and DISABLED.

## Operation
- Timestamp counter: free-running from 0 after reset, +1 per cycle, wraps modulo 2^TS_WIDTH.
- FSM states and transitions:
  - DISABLED: go to ARM when `enable` = 1.
  - ARM: write addr 2, data 1. Go to IDLE.
  - IDLE:
    - If `enable` = 0, go to DISARM.
    - Otherwise, if `irq` = 1, latch the timestamp and go to CAP_A.
  - CAP_A: read addr 3. Go to CAP_D.
  - CAP_D: sample `avm_readdata[0]`.
    - If it is 0 (spurious), go to IDLE with no event and no count.
    - If it is 1, go to CLR.
  - CLR: write addr 3, data 0. Go to LVL_A.
  - LVL_A: read addr 0. Go to LVL_D.
  - LVL_D: sample `avm_readdata[0]` into the level register. Go to REPORT.
  - REPORT: `evt_count` +1 (wraps). Go to IDLE.
  - DISARM: write addr 2, data 0. Go to DISABLED.
- `enable` falling during CAP_A..REPORT: the sequence completes, then IDLE goes to DISARM on the next cycle. An `irq` seen in that IDLE cycle is ignored.
- Bus idle values, outside ARM, DISARM, CLR and the read-address states: `avm_chipselect` = 0, `avm_write_n` = 1, `avm_address` = 0, `avm_writedata` = 0.
- Read-data states CAP_D and LVL_D drive idle values.
- Event output register, updated in REPORT:
  - Loads level, timestamp and the new count, and sets `evt_valid`, if the register is empty or is handshaken in that same cycle.
  - Otherwise the new event is dropped, the old event is held, `overflow` = 1, and the count still increments.
  - The FSM never stalls on `evt_ready`.
- `evt_valid` clears on handshake unless reloaded in the same cycle.
- `overflow`: `clr_overflow` wins over a same-cycle set.
- An edge arriving at the PIO in the same cycle as the CLR write is lost: the slave gives clear priority. This is an accepted limitation.

## Timing
- Reset values:
  - FSM = DISABLED; timestamp = 0; `evt_count` = 0.
  - `evt_valid` = 0, `evt_level` = 0, `evt_timestamp` = 0, `overflow` = 0, `busy` = 0.
  - Bus outputs at idle values.
- Enable to armed: `enable` high in cycle 0 gives DISABLED in cycle 0, the ARM write in cycle 1, and IDLE in cycle 2.
- Service latency: `irq` sampled in IDLE at cycle 0.
  - Cycle 1: addr-3 read. Cycle 2: capture sampled. Cycle 3: clear write.
  - Cycle 4: addr-0 read. Cycle 5: level sampled. Cycle 6: REPORT.
  - `evt_valid` = 1 from cycle 7.
  - Earliest next `irq` sample is cycle 7.
- `busy` is a registered decode of state.

## Test plan
- Reset mid-service, with `reset_n` low in CLR: all outputs return to reset values at once; after release the FSM re-arms, and its first access is the ARM write with mask 1.
- Single edge: enable, then a rising pin edge with the pin held at 1. Required:
  - Bus trace is write 2/1, read 3, write 3/0, read 0.
  - `evt_valid` at irq+7, with `evt_level` = 1, `evt_count` = 1, and `evt_timestamp` equal to the counter value at the irq cycle.
- Backpressure: `evt_ready` = 0, three edges spaced 20 cycles apart. Required: first event held with `evt_count` = 1, `overflow` = 1 after the second event, internal count = 3; the next accepted event shows `evt_count` = 4.
- Spurious: force `irq` = 1 while the capture register reads 0. Required: no CLR write, no event, count unchanged, return to IDLE.
- Disable mid-service, with `enable` dropped in CAP_D. Required: sequence completes and the event is reported, followed by the write 2/0 and DISABLED; later edges produce no bus activity.
- Simultaneous REPORT and handshake, with `evt_ready` = 1 in the REPORT cycle while an old event is pending. Required: old event consumed, new event loaded, `overflow` stays 0.

Source files
------------

// File: rtl/g_sensor_int_servicer.sv
// g_sensor_int_servicer
// Services the accelerometer INT edge-capture PIO from hardware. It arms the
// PIO irq mask, waits for irq, reads and clears edge capture, reads the live
// pin level and publishes a timestamped event on a valid/ready stream.
//
// Event stream handshake: evt_valid/evt_level/evt_timestamp/evt_count are
// registered and stay stable while evt_valid is high. An event is transferred
// in any cycle where evt_valid && evt_ready at the rising clock edge. The
// producer never waits on evt_ready: a new event that finds the output
// register full and not being drained is dropped and flags overflow.
module g_sensor_int_servicer #(
  parameter int TS_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic [1:0]           avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata,
  input  logic                 irq,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic                 evt_level,
  output logic [TS_WIDTH-1:0]  evt_timestamp,
  output logic [CNT_WIDTH-1:0] evt_count,
  output logic                 overflow,
  input  logic                 clr_overflow,
  output logic                 busy
);

  // PIO register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam logic [TS_WIDTH-1:0]  TS_ONE  = TS_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [3:0] {
    S_DISABLED = 4'd0,
    S_ARM      = 4'd1,
    S_IDLE     = 4'd2,
    S_CAP_A    = 4'd3,
    S_CAP_D    = 4'd4,
    S_CLR      = 4'd5,
    S_LVL_A    = 4'd6,
    S_LVL_D    = 4'd7,
    S_REPORT   = 4'd8,
    S_DISARM   = 4'd9
  } state_t;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [TS_WIDTH-1:0]    ts_q;
  logic [TS_WIDTH-1:0]    ts_lat_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic                   level_q;
  logic                   in_report;
  logic                   out_free;
  logic                   unused_rd_bits;

  // Only bit 0 of the single-bit PIO carries information.
  assign unused_rd_bits = ^avm_readdata[31:1];

  assign in_report = (state_q == S_REPORT);
  // Output register can take a new event if empty or drained this cycle.
  assign out_free  = !evt_valid || evt_ready;
  assign cnt_nxt   = cnt_q + CNT_ONE;

  // Next-state decode of the service sequence.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_DISABLED: if (enable) state_nxt = S_ARM;
      S_ARM:      state_nxt = S_IDLE;
      S_IDLE: begin
        if (!enable)  state_nxt = S_DISARM;
        else if (irq) state_nxt = S_CAP_A;
      end
      S_CAP_A:    state_nxt = S_CAP_D;
      S_CAP_D:    state_nxt = avm_readdata[0] ? S_CLR : S_IDLE;
      S_CLR:      state_nxt = S_LVL_A;
      S_LVL_A:    state_nxt = S_LVL_D;
      S_LVL_D:    state_nxt = S_REPORT;
      S_REPORT:   state_nxt = S_IDLE;
      S_DISARM:   state_nxt = S_DISABLED;
      default:    state_nxt = S_DISABLED;
    endcase
  end

  // State register plus bus strobes and busy, registered from the next state
  // so they are aligned with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_DISABLED;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= ADDR_DATA;
      avm_writedata  <= 32'd0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= ADDR_DATA;
      avm_writedata  <= 32'd0;
      busy           <= !((state_nxt == S_IDLE) || (state_nxt == S_DISABLED));
      case (state_nxt)
        S_ARM: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_MASK;
          avm_writedata  <= 32'd1;
        end
        S_DISARM: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_MASK;
        end
        S_CAP_A: begin
          avm_chipselect <= 1'b1;
          avm_address    <= ADDR_EDGE;
        end
        S_CLR: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= ADDR_EDGE;
        end
        S_LVL_A: begin
          avm_chipselect <= 1'b1;
          avm_address    <= ADDR_DATA;
        end
        default: ;
      endcase
    end
  end

  // Free-running timestamp counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_q + TS_ONE;
  end

  // Per-event working registers: irq timestamp, pin level, serviced count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_lat_q <= '0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if ((state_q == S_IDLE) && enable && irq) ts_lat_q <= ts_q;
      if (state_q == S_LVL_D)                   level_q  <= avm_readdata[0];
      if (in_report)                            cnt_q    <= cnt_nxt;
    end
  end

  // Event output register: load on REPORT when free, else hold and drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid     <= 1'b0;
      evt_level     <= 1'b0;
      evt_timestamp <= '0;
      evt_count     <= '0;
    end else if (in_report && out_free) begin
      evt_valid     <= 1'b1;
      evt_level     <= level_q;
      evt_timestamp <= ts_lat_q;
      evt_count     <= cnt_nxt;
    end else if (evt_valid && evt_ready) begin
      evt_valid     <= 1'b0;
    end
  end

  // Sticky drop flag; an explicit clear beats a same-cycle drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     overflow <= 1'b0;
    else if (clr_overflow)            overflow <= 1'b0;
    else if (in_report && !out_free)  overflow <= 1'b1;
  end

endmodule
